// File: rtl/reaction_session_controller.sv
// rtl/reaction_session_controller.sv - multi-round reaction-time session sequencer
// Optional false-start retry behaviour is enabled by defining RTB_FALSE_START_RETRY_EN.
module reaction_session_controller #(
  parameter int ROUNDS_LOG2    = 2,
  parameter int TIME_W         = 14,
  parameter int GAP_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   session_start,
  input  logic                   session_abort,
  output logic                   bench_start,
  input  logic                   bench_done,
  input  logic                   bench_early,
  input  logic [TIME_W-1:0]      bench_time,
  output logic                   busy,
  output logic [ROUNDS_LOG2-1:0] round_idx,
  output logic                   session_done,
  output logic [TIME_W-1:0]      last_time,
  output logic [TIME_W-1:0]      best_time,
  output logic [TIME_W-1:0]      avg_time,
  output logic [3:0]             false_starts
);

  localparam int SUM_W = TIME_W + ROUNDS_LOG2;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_GAP, S_REPORT} state_e;

  state_e                 state_q, state_d;
  logic [TO_W-1:0]        timer_q, timer_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [ROUNDS_LOG2-1:0] round_q, round_d;
  logic [TIME_W-1:0]      last_q, last_d;
  logic [TIME_W-1:0]      best_q, best_d;
  logic [TIME_W-1:0]      avg_q, avg_d;
  logic [3:0]             false_q, false_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   start_q, start_d;
  logic                   record;
  logic [TIME_W-1:0]      rec_time;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      gap_q   <= '0;
      sum_q   <= '0;
      round_q <= '0;
      last_q  <= '0;
      best_q  <= '0;
      avg_q   <= '0;
      false_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      sum_q   <= sum_d;
      round_q <= round_d;
      last_q  <= last_d;
      best_q  <= best_d;
      avg_q   <= avg_d;
      false_q <= false_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    sum_d    = sum_q;
    round_d  = round_q;
    last_d   = last_q;
    best_d   = best_q;
    avg_d    = avg_q;
    false_d  = false_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    record   = 1'b0;
    rec_time = '1;

    // Abort freezes all results; only the sequencing state is unwound.
    if (session_abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (session_start) begin
          state_d = S_ARM;
          round_d = '0;
          false_d = '0;
          sum_d   = '0;
          best_d  = '1;
          busy_d  = 1'b1;
        end
        S_ARM: begin
          timer_d = TO_LOAD;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bench_done) begin
            if (bench_early) begin
              false_d = (false_q == 4'hF) ? false_q : false_q + 4'd1;
`ifdef RTB_FALSE_START_RETRY_EN
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
`else
              record  = 1'b1;
`endif
            end else begin
              record   = 1'b1;
              rec_time = bench_time;
            end
          end else if (timer_q == '0) begin
            record = 1'b1;
          end else begin
            timer_d = timer_q - TO_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == '0) state_d = S_ARM;
          else             gap_d   = gap_q - GAP_W'(1);
        end
        S_REPORT: begin
          avg_d   = TIME_W'(sum_q >> ROUNDS_LOG2);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (record) begin
        last_d = rec_time;
        if (rec_time < best_q) best_d = rec_time;
        sum_d = sum_q + SUM_W'(rec_time);
        if (round_q == '1) begin
          state_d = S_REPORT;
        end else begin
          round_d = round_q + ROUNDS_LOG2'(1);
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end
    end

    start_d = (state_d == S_ARM);
  end

  assign bench_start  = start_q;
  assign busy         = busy_q;
  assign round_idx    = round_q;
  assign session_done = done_q;
  assign last_time    = last_q;
  assign best_time    = best_q;
  assign avg_time     = avg_q;
  assign false_starts = false_q;

endmodule

// File: tb/tb_reaction_session_controller.sv
// tb/tb_reaction_session_controller.sv - randomized self-checking bench for reaction_session_controller
module tb_reaction_session_controller;
  localparam int RL = 2;
  localparam int TW = 14;
  localparam int GAP = 4;
  localparam int TO = 1000;
  localparam int NR = 4;
  localparam int PEN = 16383;
`ifdef RTB_FALSE_START_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic session_start = 1'b0;
  logic session_abort = 1'b0;
  logic bench_done = 1'b0;
  logic bench_early = 1'b0;
  logic [TW-1:0] bench_time = '0;
  logic bench_start, busy, session_done;
  logic [RL-1:0] round_idx;
  logic [TW-1:0] last_time, best_time, avg_time;
  logic [3:0] false_starts;

  int total_cnt = 0;
  int pass_cnt = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int kind_q[$];
  int time_q[$];
  int dly_q[$];
  int rec_n = 0;
  int exp_avg = 0;

  reaction_session_controller #(
    .ROUNDS_LOG2(RL), .TIME_W(TW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .session_start(session_start), .session_abort(session_abort),
    .bench_start(bench_start), .bench_done(bench_done), .bench_early(bench_early),
    .bench_time(bench_time), .busy(busy), .round_idx(round_idx),
    .session_done(session_done), .last_time(last_time), .best_time(best_time),
    .avg_time(avg_time), .false_starts(false_starts)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bench_start === 1'b1) start_cnt <= start_cnt + 1;
    if (session_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Outcome kinds: 0 valid time, 1 false start, 2 timeout, 3 done exactly at timeout expiry.
  task automatic clear_outs();
    kind_q = {}; time_q = {}; dly_q = {}; rec_n = 0;
  endtask

  task automatic push_out(input int k, input int t, input int d);
    kind_q.push_back(k); time_q.push_back(t); dly_q.push_back(d);
    if (k != 1 || !RETRY) rec_n++;
  endtask

  task automatic wait_start(output bit ok);
    ok = (bench_start === 1'b1);
    for (int i = 0; i < 1200; i++)
      if (!ok) begin
        @(negedge clk);
        ok = (bench_start === 1'b1);
      end
  endtask

  task automatic run_session(input bit poke);
    int rec[$];
    int early_n, sum, eb, el, ea, nrec, adv, prev, s0, d0;
    bit ok;
    rec = {}; early_n = 0;
    foreach (kind_q[i]) begin
      if (kind_q[i] == 1) begin
        early_n++;
        if (!RETRY) rec.push_back(PEN);
      end else if (kind_q[i] == 2) rec.push_back(PEN);
      else rec.push_back(time_q[i]);
    end
    sum = 0; eb = PEN;
    foreach (rec[i]) begin
      sum += rec[i];
      if (rec[i] < eb) eb = rec[i];
    end
    el = rec[rec.size()-1];
    ea = sum / NR;

    s0 = start_cnt; d0 = done_cnt; nrec = 0; prev = 0;
    @(negedge clk); session_start = 1'b1;
    @(negedge clk); session_start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_on_accept: got %b, required 1", busy); else pass_cnt++;
    for (int i = 0; i < kind_q.size(); i++) begin
      wait_start(ok);
      total_cnt++;
      if (!ok) $display("FAIL start_wait round %0d: got no pulse, required a pulse", i); else pass_cnt++;
      total_cnt++;
      if (round_idx !== RL'(nrec)) $display("FAIL round_idx at start %0d: got %0d, required %0d", i, round_idx, nrec);
      else pass_cnt++;
      if (nrec > 0) begin
        total_cnt++;
        if (last_time !== TW'(prev)) $display("FAIL last_time before start %0d: got %0d, required %0d", i, last_time, prev);
        else pass_cnt++;
      end
      @(negedge clk); adv = 1;
      total_cnt++;
      if (bench_start !== 1'b0) $display("FAIL start_width round %0d: got %b, required 0", i, bench_start); else pass_cnt++;
      if (poke) begin
        session_start = 1'b1; @(negedge clk); session_start = 1'b0; adv = 2;
      end
      if (kind_q[i] != 2) begin
        repeat (dly_q[i] - adv) @(negedge clk);
        bench_time = TW'(time_q[i]); bench_early = (kind_q[i] == 1); bench_done = 1'b1;
        @(negedge clk); bench_done = 1'b0; bench_early = 1'b0;
        if (kind_q[i] != 1 || !RETRY) begin
          prev = (kind_q[i] == 1) ? PEN : time_q[i];
          total_cnt++;
          if (last_time !== TW'(prev)) $display("FAIL last_time after done %0d: got %0d, required %0d", i, last_time, prev);
          else pass_cnt++;
        end
      end else prev = PEN;
      if (kind_q[i] != 1 || !RETRY) nrec++;
    end
    ok = 1'b0;
    for (int i = 0; i < 1200; i++)
      if (!ok) begin
        @(negedge clk);
        ok = (session_done === 1'b1);
      end
    total_cnt++;
    if (!ok) $display("FAIL session_done_wait: got no pulse, required a pulse"); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL busy_at_done: got %b, required 0", busy); else pass_cnt++;
    total_cnt++;
    if (avg_time !== TW'(ea)) $display("FAIL avg_time: got %0d, required %0d", avg_time, ea); else pass_cnt++;
    total_cnt++;
    if (best_time !== TW'(eb)) $display("FAIL best_time: got %0d, required %0d", best_time, eb); else pass_cnt++;
    total_cnt++;
    if (last_time !== TW'(el)) $display("FAIL last_time final: got %0d, required %0d", last_time, el); else pass_cnt++;
    total_cnt++;
    if (false_starts !== 4'(early_n)) $display("FAIL false_starts: got %0d, required %0d", false_starts, early_n);
    else pass_cnt++;
    total_cnt++;
    if (start_cnt - s0 != kind_q.size())
      $display("FAIL start_pulses: got %0d, required %0d", start_cnt - s0, kind_q.size());
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (session_done !== 1'b0 || done_cnt - d0 != 1)
      $display("FAIL done_pulses: got %0d (level %b), required 1 single-cycle", done_cnt - d0, session_done);
    else pass_cnt++;
    exp_avg = ea;
  endtask

  task automatic test_reset();
    bit ok;
    logic [3*TW+RL+7:0] outs;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bench_start, busy, round_idx, session_done, last_time, best_time, avg_time, false_starts};
    total_cnt++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h, required 0", outs); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk); session_start = 1'b1;
    @(negedge clk); session_start = 1'b0;
    wait_start(ok);
    repeat (5) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL busy_in_wait: got %b, required 1", busy); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    outs = {bench_start, busy, round_idx, session_done, last_time, best_time, avg_time, false_starts};
    total_cnt++;
    if (outs !== '0) $display("FAIL reset_async: got %h, required 0", outs); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bench_start !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    total_cnt++;
    if (!ok) $display("FAIL idle_after_reset: got activity, required bench_start=0 busy=0"); else pass_cnt++;
    exp_avg = 0;
  endtask

  task automatic test_normal();
    clear_outs();
    push_out(0, 230, 12); push_out(0, 450, 7); push_out(0, 180, 30); push_out(0, 340, 3);
    run_session(1'b0);
  endtask

  task automatic test_timeout();
    clear_outs();
    push_out(2, 0, 0); push_out(0, 100, 9); push_out(0, 200, 5); push_out(0, 300, 20);
    run_session(1'b0);
  endtask

  task automatic test_false_start();
    clear_outs();
    push_out(0, 230, 6); push_out(1, 77, 8);
    while (rec_n < NR) push_out(0, 500 + 100 * rec_n, 10);
    run_session(1'b0);
  endtask

  task automatic test_abort();
    bit ok;
    int s0, d0;
    @(negedge clk); session_start = 1'b1;
    @(negedge clk); session_start = 1'b0;
    wait_start(ok);
    repeat (4) @(negedge clk);
    bench_time = 14'd230; bench_done = 1'b1;
    @(negedge clk); bench_done = 1'b0;
    wait_start(ok);
    total_cnt++;
    if (!ok) $display("FAIL abort_round1_start: got no pulse, required a pulse"); else pass_cnt++;
    repeat (3) @(negedge clk);
    s0 = start_cnt; d0 = done_cnt;
    session_abort = 1'b1;
    @(negedge clk); session_abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %b, required 0", busy); else pass_cnt++;
    total_cnt++;
    if (last_time !== 14'd230 || best_time !== 14'd230)
      $display("FAIL abort_hold: got last=%0d best=%0d, required 230/230", last_time, best_time);
    else pass_cnt++;
    total_cnt++;
    if (avg_time !== TW'(exp_avg)) $display("FAIL abort_avg: got %0d, required %0d", avg_time, exp_avg); else pass_cnt++;
    bench_time = 14'd500; bench_done = 1'b1;
    @(negedge clk); bench_done = 1'b0;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (last_time !== 14'd230) $display("FAIL abort_done_ignored: got %0d, required 230", last_time); else pass_cnt++;
    total_cnt++;
    if (start_cnt != s0 || done_cnt != d0)
      $display("FAIL abort_quiet: got starts=%0d dones=%0d, required 0/0", start_cnt - s0, done_cnt - d0);
    else pass_cnt++;
    clear_outs();
    push_out(0, 610, 4); push_out(0, 620, 5); push_out(0, 630, 6); push_out(0, 640, 7);
    run_session(1'b0);
  endtask

  task automatic test_collision();
    clear_outs();
    push_out(3, 999, TO); push_out(0, 1500, 11); push_out(0, 2000, 4); push_out(0, 3000, 8);
    run_session(1'b1);
  endtask

  task automatic test_random();
    int r, k, t, d;
    for (int s = 0; s < 4; s++) begin
      clear_outs();
      while (rec_n < NR) begin
        r = $urandom_range(0, 19);
        k = (r < 13) ? 0 : (r < 16) ? 1 : (r < 18) ? 2 : 3;
        t = $urandom_range(0, PEN);
        d = (k == 3) ? TO : $urandom_range(3, 60);
        push_out(k, t, d);
      end
      run_session(s[0]);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_false_start();
    test_abort();
    test_collision();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reaction_session_controller.md
# reaction_session_controller

Sequences a multi-round reaction-time session on top of `reaction_time_benchmark`. It issues one start pulse per round, waits for the round result or a timeout, and enforces a pause between rounds. It accumulates last, best and average reaction time, and counts false starts. It sits between the user start/abort controls and the benchmark core; its result outputs feed the display path.

## Interface
Parameters:
- `ROUNDS_LOG2`, 2: session length is 2^ROUNDS_LOG2 rounds.
- `TIME_W`, 14: width of reaction times in ms.
- `GAP_CYCLES`, 50000: inter-round pause in clocks; must be ≥1.
- `TIMEOUT_CYCLES`, 500000: maximum WAIT duration in clocks; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `session_start`  in  1  start request; sampled only in IDLE.
- `session_abort`  in  1  abort request; honoured in any state.
- `bench_start`  out  1  one-cycle start pulse to the benchmark core.
- `bench_done`  in  1  one-cycle result strobe from the core.
- `bench_early`  in  1  false-start flag; valid only while `bench_done`=1.
- `bench_time`  in  TIME_W  measured ms; valid only while `bench_done`=1.
- `busy`  out  1  high from session accept until REPORT completes.
- `round_idx`  out  ROUNDS_LOG2  current round number, 0-based.
- `session_done`  out  1  one-cycle pulse when a session completes.
- `last_time`  out  TIME_W  most recent recorded round time.
- `best_time`  out  TIME_W  minimum recorded time in the session.
- `avg_time`  out  TIME_W  session average.
- `false_starts`  out  4  false-start count for the session, saturating at 15.

## Operation
- States: IDLE, ARM, WAIT, GAP, REPORT. All outputs are registered.
- **IDLE**
  - `session_start`=1 moves to ARM.
  - On that transition: clear `round_idx`, `false_starts` and the sum; set `best_time` to all-ones; raise `busy`.
- **ARM**
  - `bench_start`=1 for exactly this state's cycle.
  - Load the timeout counter; go to WAIT.
- **WAIT**
  - `bench_done` with `bench_early`=0 records `bench_time`: `last_time` ← t; `best_time` ← min(best_time, t); sum += t.
  - Timeout expiry records the value 2^TIME_W−1 by the same rule.
  - `bench_early` handling depends on the configuration macro (see Configuration).
  - After a record: if `round_idx` = 2^ROUNDS_LOG2−1, go to REPORT; otherwise increment `round_idx` and go to GAP.
  - `bench_done` arriving on the same cycle as timeout expiry: `bench_done` wins.
- **GAP**
  - Counts GAP_CYCLES clocks, then goes to ARM.
  - `bench_done` is ignored in this state.
- **REPORT**
  - `avg_time` ← sum >> ROUNDS_LOG2 (truncating).
  - Pulse `session_done`; drop `busy`; return to IDLE.
- Arithmetic:
  - Sum is TIME_W+ROUNDS_LOG2 bits wide and cannot overflow.
  - `best_time` compare is unsigned.
- `session_abort`:
  - Any state goes to IDLE on the next edge; `busy`=0; no `session_done` pulse.
  - `last_time`, `best_time` and `false_starts` hold their partial values; `avg_time` is unchanged.
  - Abort takes priority over every other event in the same cycle.
- `session_start` while busy is ignored.
- `bench_done` outside WAIT is ignored.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including `best_time`.
  - All counters and the sum are 0.
- Session accept: `session_start` high at edge N → `busy`=1 and state ARM after N; `bench_start` is high during the cycle after N.
- Record: `bench_done` sampled at edge M → `last_time`, `best_time` and `round_idx` are updated after M.
- Timeout: expiry occurs TIMEOUT_CYCLES clocks after entering WAIT.
- Round spacing: `bench_start` pulses are separated by at least GAP_CYCLES+2 clocks.
- Session end: REPORT lasts 1 cycle. `session_done` and `avg_time` become valid together; `busy` falls on the same edge.

## Configuration
- `RTB_FALSE_START_RETRY_EN` defined:
  - A round with `bench_early` is discarded: no record, `round_idx` unchanged, `false_starts` incremented (saturating).
  - State goes to GAP, and the round is re-armed afterwards.
- `RTB_FALSE_START_RETRY_EN` undefined:
  - A round with `bench_early` is recorded as 2^TIME_W−1 (penalty) and advances like a normal round.
  - `false_starts` still increments.

## Test plan
All scenarios use ROUNDS_LOG2=2, TIME_W=14, GAP_CYCLES=4, TIMEOUT_CYCLES=1000.

1. **Reset:** drive `rst`=0 mid-WAIT → all outputs 0 immediately; after release, the state is IDLE and `bench_start` stays 0.
2. **Normal session:** four rounds returning 230, 450, 180, 340 → `best_time`=180, `avg_time`=300, `last_time`=340, exactly 4 `bench_start` pulses, one `session_done` pulse, `busy`=0 after it.
3. **Timeout:** no `bench_done` for 1000 cycles in round 0 → `last_time`=16383, round advances. Remaining rounds return 100, 200, 300 → `best_time`=100, `avg_time`=4245.
4. **False start in round 1:**
   - Macro defined: `false_starts`=1, 5 `bench_start` pulses total, all four valid times recorded.
   - Macro undefined: 16383 is recorded and 4 pulses total.
5. **Abort:** assert `session_abort` during WAIT → `busy`=0 next cycle, no `session_done`; a subsequent `bench_done` is ignored; `session_start` then begins a fresh session with `round_idx`=0.
6. **Collisions:**
   - `bench_done`=1 with `bench_time`=999 on the cycle the timeout expires → 999 is recorded.
   - `session_start` pulsed while busy → no effect.
